// File: rtl/bcd_display_mux2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_mux2_pkg
// Description : Shared types and constants for the 2-digit multiplexed
//               7-segment display driver: display-phase enum, active-low
//               segment patterns (seg[0]=a ... seg[6]=g) and anode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_display_mux2_pkg;

    // Display phases, in cycling order GAP1 -> ONES -> GAP0 -> TENS -> GAP1
    typedef enum logic [1:0] {
        S_GAP1 = 2'd0,
        S_ONES = 2'd1,
        S_GAP0 = 2'd2,
        S_TENS = 2'd3
    } state_t;

    // Active-low segment patterns for decimal digits
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;   // segment g only
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] AN_OFF   = 2'b11;

endpackage : bcd_display_mux2_pkg
`default_nettype wire

// File: rtl/bcd_display_mux2_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD to active-low 7-segment decoder. Non-BCD
//               codes (10-15) show a dash.
// Ports       : bcd [3:0] in  - digit value
//               seg [6:0] out - active-low segments, seg[0]=a ... seg[6]=g
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import bcd_display_mux2_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_display_mux2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_mux2
// Description : Time-multiplexes two BCD digits onto a common-anode 2-digit
//               7-segment display, with a blanking guard between digits and
//               once-per-frame capture of the digit inputs.
// Ports       : clk        in      - system clock
//               rst        in      - asynchronous active-low reset
//               en         in      - display enable (0 blanks, timing runs on)
//               d1  [3:0]  in      - ones digit
//               d10 [3:0]  in      - tens digit
//               seg [6:0]  out     - active-low segments (registered)
//               an  [1:0]  out     - active-low anodes, an[0]=ones (registered)
//               frame_tick out     - one-cycle pulse after digit capture
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux2
    import bcd_display_mux2_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int GUARD         = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] d1,
    input  logic [3:0] d10,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int c_max_len = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
    localparam int c_cnt_w   = (c_max_len > 1) ? $clog2(c_max_len) : 1;

    localparam logic [c_cnt_w-1:0] c_refresh_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_guard_last   = c_cnt_w'(GUARD - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [3:0]           r_d1;
    logic [3:0]           r_d10;
    logic [3:0]           w_d1_next;
    logic [3:0]           w_d10_next;
    logic                 w_last;
    logic                 w_capture;
    logic [3:0]           w_digit;
    logic [6:0]           w_dec;
    logic [6:0]           w_seg_next;
    logic [1:0]           w_an_next;
    logic [6:0]           r_seg;
    logic [1:0]           r_an;
    logic                 r_frame_tick;

    // Single decoder shared by both digit slots: it decodes whichever digit
    // will be shown after the coming edge.
    bcd_to_seg7 u_dec (
        .bcd (w_digit),
        .seg (w_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_GAP1;
            r_cnt        <= '0;
            r_d1         <= 4'd0;
            r_d10        <= 4'd0;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_d1         <= w_d1_next;
            r_d10        <= w_d10_next;
            r_seg        <= w_seg_next;
            r_an         <= w_an_next;
            r_frame_tick <= w_capture;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_capture    = 1'b0;
        w_an_next    = AN_OFF;
        w_seg_next   = SEG_OFF;

        if ((r_state == S_ONES) || (r_state == S_TENS)) begin
            w_last = (r_cnt == c_refresh_last);
        end else begin
            w_last = (r_cnt == c_guard_last);
        end

        if (w_last) begin
            w_cnt_next = '0;
            case (r_state)
                S_GAP1: begin
                    w_state_next = S_ONES;
                    w_capture    = 1'b1;
                end
                S_ONES:  w_state_next = S_GAP0;
                S_GAP0:  w_state_next = S_TENS;
                S_TENS:  w_state_next = S_GAP1;
                default: w_state_next = S_GAP1;
            endcase
        end

        // Capture uses the inputs present at the GAP1->ONES edge, and the
        // outputs loaded on that same edge already reflect the new digits.
        w_d1_next  = w_capture ? d1  : r_d1;
        w_d10_next = w_capture ? d10 : r_d10;
        w_digit    = (w_state_next == S_TENS) ? w_d10_next : w_d1_next;

        if (en) begin
            case (w_state_next)
                S_ONES: begin
                    w_an_next  = 2'b10;
                    w_seg_next = w_dec;
                end
                S_TENS: begin
                    if (!((BLANK_LEADING != 0) && (w_d10_next == 4'd0))) begin
                        w_an_next  = 2'b01;
                        w_seg_next = w_dec;
                    end
                end
                default: begin
                    w_an_next  = AN_OFF;
                    w_seg_next = SEG_OFF;
                end
            endcase
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule : bcd_display_mux2
`default_nettype wire

// File: tb/tb_bcd_display_mux2.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_mux2
// Description : Self-checking bench for bcd_display_mux2 (REFRESH_DIV=4,
//               GUARD=2). Two instances share stimulus: one with leading-zero
//               blanking, one without. A frame-position model predicts the
//               outputs on every cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_mux2;

    localparam int R = 4;
    localparam int G = 2;
    localparam int F = 2*R + 2*G;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [3:0] d1  = 4'd0;
    logic [3:0] d10 = 4'd0;

    logic [6:0] seg, seg_nb;
    logic [1:0] an,  an_nb;
    logic       frame_tick, frame_tick_nb;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    bcd_display_mux2 #(.REFRESH_DIV(R), .GUARD(G), .BLANK_LEADING(1)) dut (
        .clk(clk), .rst(rst), .en(en), .d1(d1), .d10(d10),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    bcd_display_mux2 #(.REFRESH_DIV(R), .GUARD(G), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .d1(d1), .d10(d10),
        .seg(seg_nb), .an(an_nb), .frame_tick(frame_tick_nb)
    );

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [0:15];
    initial begin
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24;
        seg_tab[3]  = 7'h30; seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12;
        seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78; seg_tab[8]  = 7'h00;
        seg_tab[9]  = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
    end

    // Position s in the frame after the n-th edge following reset release:
    // [0,G) gap, [G,G+R) ones, [G+R,2G+R) gap, [2G+R,F) tens.
    function automatic int pos(int n);
        return n % F;
    endfunction

    function automatic logic [1:0] f_an(int s, logic [3:0] tens, bit bl, logic e);
        if (!e) return 2'b11;
        if (s >= G && s < G + R) return 2'b10;
        if (s >= 2*G + R) return (bl && tens == 4'd0) ? 2'b11 : 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [6:0] f_seg(int s, logic [3:0] ones, logic [3:0] tens,
                                         bit bl, logic e);
        if (!e) return 7'h7F;
        if (s >= G && s < G + R) return seg_tab[ones];
        if (s >= 2*G + R) return (bl && tens == 4'd0) ? 7'h7F : seg_tab[tens];
        return 7'h7F;
    endfunction

    int         m_t    = 0;
    logic [3:0] m_sh1  = 4'd0;
    logic [3:0] m_sh10 = 4'd0;
    logic [1:0] exp_an = 2'b11, exp_an_nb = 2'b11;
    logic [6:0] exp_seg = 7'h7F, exp_seg_nb = 7'h7F;
    logic       exp_tick = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t        <= 0;
            m_sh1      <= 4'd0;
            m_sh10     <= 4'd0;
            exp_an     <= 2'b11;
            exp_seg    <= 7'h7F;
            exp_an_nb  <= 2'b11;
            exp_seg_nb <= 7'h7F;
            exp_tick   <= 1'b0;
        end else begin
            m_t      <= m_t + 1;
            exp_tick <= (pos(m_t + 1) == G);
            if (pos(m_t + 1) == G) begin
                m_sh1      <= d1;
                m_sh10     <= d10;
                exp_an     <= f_an(pos(m_t + 1), d10, 1'b1, en);
                exp_seg    <= f_seg(pos(m_t + 1), d1, d10, 1'b1, en);
                exp_an_nb  <= f_an(pos(m_t + 1), d10, 1'b0, en);
                exp_seg_nb <= f_seg(pos(m_t + 1), d1, d10, 1'b0, en);
            end else begin
                exp_an     <= f_an(pos(m_t + 1), m_sh10, 1'b1, en);
                exp_seg    <= f_seg(pos(m_t + 1), m_sh1, m_sh10, 1'b1, en);
                exp_an_nb  <= f_an(pos(m_t + 1), m_sh10, 1'b0, en);
                exp_seg_nb <= f_seg(pos(m_t + 1), m_sh1, m_sh10, 1'b0, en);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL model_blank t=%0t: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                         $time, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            n_checks++;
            if (an_nb !== exp_an_nb || seg_nb !== exp_seg_nb || frame_tick_nb !== exp_tick) begin
                n_fail++;
                $display("FAIL model_noblank t=%0t: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                         $time, an_nb, seg_nb, frame_tick_nb, exp_an_nb, exp_seg_nb, exp_tick);
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic lit(input string name, input logic [1:0] a, input logic [6:0] s,
                       input logic t);
        n_checks++;
        if (an !== a || seg !== s || frame_tick !== t) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                     name, an, seg, frame_tick, a, s, t);
        end
    endtask

    task automatic lit_nb(input string name, input logic [1:0] a, input logic [6:0] s);
        n_checks++;
        if (an_nb !== a || seg_nb !== s) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                     name, an_nb, seg_nb, a, s);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low for 5 cycles
        step(5);
        chk_en = 1'b1;
        lit("reset_hold", 2'b11, 7'h7F, 1'b0);

        // Basic frame: ones 7, tens 4
        d1 = 4'd7; d10 = 4'd4;
        #1 rst = 1'b1;
        step(1);  lit("gap1_first",  2'b11, 7'h7F, 1'b0);
        step(1);  lit("ones_entry",  2'b10, 7'h78, 1'b1);     // edge 2
        step(1);  lit("tick_single", 2'b10, 7'h78, 1'b0);     // edge 3
        step(3);  lit("gap0",        2'b11, 7'h7F, 1'b0);     // edge 6
        step(2);  lit("tens_4",      2'b01, 7'h19, 1'b0);     // edge 8

        // Mid-TENS input change must not affect the current frame
        d1 = 4'd2;
        step(2);  lit("tens_hold",   2'b01, 7'h19, 1'b0);     // edge 10
        step(2);  lit("gap1_again",  2'b11, 7'h7F, 1'b0);     // edge 12
        step(2);  lit("ones_2",      2'b10, 7'h24, 1'b1);     // edge 14

        // Leading-zero blanking
        d1 = 4'd5; d10 = 4'd0;
        step(12); lit("ones_5",      2'b10, 7'h12, 1'b1);     // edge 26
        step(6);  lit("tens_blank",  2'b11, 7'h7F, 1'b0);     // edge 32
        lit_nb("tens_zero_nb", 2'b01, 7'h40);

        // Non-BCD value shows a dash
        d1 = 4'hC; d10 = 4'd9;
        step(6);  lit("ones_dash",   2'b10, 7'h3F, 1'b1);     // edge 38
        step(6);  lit("tens_9",      2'b01, 7'h10, 1'b0);     // edge 44

        // Display disable over 7 edges (47..53) spanning the tick at edge 50
        step(2);                                              // edge 46
        en = 1'b0;
        step(1);  lit("en_off",      2'b11, 7'h7F, 1'b0);     // edge 47
        lit_nb("en_off_nb", 2'b11, 7'h7F);
        step(3);  lit("en_off_tick", 2'b11, 7'h7F, 1'b1);     // edge 50
        step(3);  lit("en_off_end",  2'b11, 7'h7F, 1'b0);     // edge 53
        en = 1'b1;
        step(3);  lit("en_resume",   2'b01, 7'h10, 1'b0);     // edge 56

        // Asynchronous reset mid-TENS, away from any clock edge
        #2 rst = 1'b0;
        #1 lit("async_reset", 2'b11, 7'h7F, 1'b0);
        lit_nb("async_reset_nb", 2'b11, 7'h7F);
        step(3);  lit("reset_held",  2'b11, 7'h7F, 1'b0);

        // Restart after mid-frame reset begins a fresh frame
        d1 = 4'd3; d10 = 4'd1;
        #1 rst = 1'b1;
        step(2);  lit("restart_ones", 2'b10, 7'h30, 1'b1);
        step(6);  lit("restart_tens", 2'b01, 7'h79, 1'b0);

        step(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #20000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bcd_display_mux2
`default_nettype wire
